// File: rtl/rf_access_ctrl_if.sv
// rf_access_ctrl_if: core, debug and RAM-side signals of the register-file controller.
interface rf_access_ctrl_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 5);
  logic                  busy;
  logic                  wbWe;
  logic [ADDR_WIDTH-1:0] wbAddr;
  logic [DATA_WIDTH-1:0] wbData;
  logic                  rdEn;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdValid;
  logic                  dbgReq;
  logic                  dbgWe;
  logic [ADDR_WIDTH-1:0] dbgAddr;
  logic [DATA_WIDTH-1:0] dbgWdata;
  logic                  dbgGnt;
  logic [DATA_WIDTH-1:0] dbgRdata;
  logic                  dbgRvalid;
  logic                  ramWe;
  logic [ADDR_WIDTH-1:0] ramWAddr;
  logic [DATA_WIDTH-1:0] ramDataIn;
  logic [ADDR_WIDTH-1:0] ramRAddr;
  logic [DATA_WIDTH-1:0] ramQ;
  modport slave (
    output busy, rdData, rdValid, dbgGnt, dbgRdata, dbgRvalid, ramWe, ramWAddr, ramDataIn, ramRAddr,
    input  wbWe, wbAddr, wbData, rdEn, rdAddr, dbgReq, dbgWe, dbgAddr, dbgWdata, ramQ
  );
  modport master (
    input  busy, rdData, rdValid, dbgGnt, dbgRdata, dbgRvalid, ramWe, ramWAddr, ramDataIn, ramRAddr,
    output wbWe, wbAddr, wbData, rdEn, rdAddr, dbgReq, dbgWe, dbgAddr, dbgWdata, ramQ
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: register-file RAM controller with post-reset clear, core/debug port arbitration and x0 zeroing.
// Define RF_BYPASS_EN to forward a same-cycle write to a same-address read.
module rf_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic           clk,
  input logic           rst,
  rf_access_ctrl_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_rd_v;
  logic                  r_dbg_v;
  logic                  r_zero;
  logic                  w_run;
  logic                  w_wb;
  logic                  w_dbg_w;
  logic                  w_dbg_r;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_q;
  always_comb begin
    w_run   = r_state == RUN && !rst;
    w_wb    = w_run && bus.wbWe && bus.wbAddr != '0;
    w_dbg_w = w_run && !w_wb && bus.dbgReq && bus.dbgWe;
    w_rd    = w_run && bus.rdEn;
    w_dbg_r = w_run && !bus.rdEn && bus.dbgReq && !bus.dbgWe;
  end
  assign bus.busy      = r_state == CLEAR;
  assign bus.dbgGnt    = w_dbg_w || w_dbg_r;
  assign bus.ramWe     = !rst && (r_state == CLEAR || w_wb || (w_dbg_w && bus.dbgAddr != '0));
  assign bus.ramWAddr  = r_state == CLEAR ? r_clr_cnt : w_wb ? bus.wbAddr : bus.dbgAddr;
  assign bus.ramDataIn = r_state == CLEAR ? '0 : w_wb ? bus.wbData : bus.dbgWdata;
  assign bus.ramRAddr  = w_rd ? bus.rdAddr : w_dbg_r ? bus.dbgAddr : r_raddr;
`ifdef RF_BYPASS_EN
  logic                  r_byp;
  logic [DATA_WIDTH-1:0] r_byp_data;
  // RAM returns old data on a same-edge collision, so capture the write for the next cycle
  always_ff @(posedge clk) begin
    if (rst) r_byp <= 1'b0;
    else r_byp <= w_run && bus.ramWe && (w_rd || w_dbg_r) && bus.ramWAddr == bus.ramRAddr;
    r_byp_data <= bus.ramDataIn;
  end
  assign w_q = r_byp ? r_byp_data : bus.ramQ;
`else
  assign w_q = bus.ramQ;
`endif
  assign bus.rdData    = r_rd_v && !r_zero ? w_q : '0;
  assign bus.dbgRdata  = r_dbg_v && !r_zero ? w_q : '0;
  assign bus.rdValid   = r_rd_v;
  assign bus.dbgRvalid = r_dbg_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_raddr   <= '0;
      r_rd_v    <= 1'b0;
      r_dbg_v   <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_rd_v  <= w_rd;
      r_dbg_v <= w_dbg_r;
      r_zero  <= bus.ramRAddr == '0;
      r_raddr <= bus.ramRAddr;
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (&r_clr_cnt) r_state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: vector table, corner-case sequences and random traffic against a register-file model.
module tb_rf_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    bit wbe; logic [AW-1:0] wba; logic [DW-1:0] wbd;
    bit rde; logic [AW-1:0] rda;
    bit dq; bit dwe; logic [AW-1:0] da; logic [DW-1:0] dd;
    bit e_gnt; bit e_we; logic [AW-1:0] e_wa;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rf_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  rf_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [DW-1:0] mem [DEPTH];
  // entry 0 returns junk so only the controller's zeroing can make x0 read as 0
  always @(posedge clk) begin
    if (bus.ramWe) mem[bus.ramWAddr] <= bus.ramDataIn;
    bus.ramQ <= bus.ramRAddr == '0 ? 32'hDEAD0000 : mem[bus.ramRAddr];
  end
  logic [DW-1:0] rf [DEPTH];
  int clr_left = DEPTH;
  bit last_gnt;
  int checks = 0;
  int errors = 0;
  vec_t vecs [8];
  task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    bus.wbWe = v.wbe; bus.wbAddr = v.wba; bus.wbData = v.wbd;
    bus.rdEn = v.rde; bus.rdAddr = v.rda;
    bus.dbgReq = v.dq; bus.dbgWe = v.dwe; bus.dbgAddr = v.da; bus.dbgWdata = v.dd;
  endtask
  task automatic idle();
    apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
  endtask
  // one clock: check the combinational response, predict, then check what the edge produced
  task automatic tick();
    bit wb, dw, dr, wen, nrv, ndv;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, val;
    #1;
    wb  = bus.wbWe && bus.wbAddr != 0;
    dw  = !wb && bus.dbgReq && bus.dbgWe;
    dr  = !bus.rdEn && bus.dbgReq && !bus.dbgWe;
    wa  = wb ? bus.wbAddr : bus.dbgAddr;
    wd  = wb ? bus.wbData : bus.dbgWdata;
    wen = wb || (dw && bus.dbgAddr != 0);
    ra  = bus.rdEn ? bus.rdAddr : bus.dbgAddr;
    val = ra == 0 ? '0 : (BYP && wen && wa == ra) ? wd : rf[ra];
    last_gnt = bus.dbgGnt;
    nrv = 0;
    ndv = 0;
    if (rst) begin
      chk("rst_we", bus.ramWe, 0);
      chk("rst_gnt", bus.dbgGnt, 0);
    end else if (clr_left > 0) begin
      chk("clr_we", bus.ramWe, 1);
      chk("clr_waddr", bus.ramWAddr, DEPTH - clr_left);
      chk("clr_din", bus.ramDataIn, 0);
      chk("clr_gnt", bus.dbgGnt, 0);
    end else begin
      chk("gnt", bus.dbgGnt, dw || dr);
      chk("we", bus.ramWe, wen);
      if (wen) begin
        chk("waddr", bus.ramWAddr, wa);
        chk("wdata", bus.ramDataIn, wd);
      end
      if (bus.rdEn || dr) chk("raddr", bus.ramRAddr, ra);
      nrv = bus.rdEn;
      ndv = dr;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      clr_left = DEPTH;
      foreach (rf[i]) rf[i] = '0;
    end else if (clr_left > 0) clr_left--;
    else if (wen) rf[wa] = wd;
    chk("busy", bus.busy, clr_left != 0);
    chk("rdValid", bus.rdValid, nrv);
    chk("rdData", bus.rdData, nrv ? val : '0);
    chk("dbgRvalid", bus.dbgRvalid, ndv);
    chk("dbgRdata", bus.dbgRdata, ndv ? val : '0);
  endtask
  initial begin
    bit hold;
    foreach (rf[i]) rf[i] = '0;
    vecs[0] = '{1, 4, 32'h44, 0, 0, 1, 1, 3, 32'hA5A5A5A5, 0, 1, 4};
    vecs[1] = '{0, 0, 0, 0, 0, 1, 1, 3, 32'hA5A5A5A5, 1, 1, 3};
    vecs[2] = '{0, 0, 0, 1, 4, 1, 0, 3, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0};
    vecs[4] = '{1, 0, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 32'h77, 1, 0, 0};
    vecs[5] = '{1, 6, 32'h66, 0, 0, 1, 0, 6, 0, 1, 1, 6};
    vecs[6] = '{1, 0, 32'h1, 1, 6, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 1, 3, 1, 0, 4, 0, 0, 0, 0};
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.rdEn = 1; bus.rdAddr = 3; bus.dbgReq = 1; bus.dbgWe = 0; bus.dbgAddr = 2;
    repeat (DEPTH) tick();
    chk("busy_done", bus.busy, 0);
    idle();
    tick();
    apply('{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tick();
    apply('{0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0});
    tick();
    chk("rd5", bus.rdData, 32'hDEADBEEF);
    apply('{1, 7, 32'h12345678, 1, 7, 0, 0, 0, 0, 0, 0, 0});
    tick();
    chk("collide7", bus.rdData, BYP ? 32'h12345678 : 32'h0);
    apply('{0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0});
    tick();
    chk("reread7", bus.rdData, 32'h12345678);
    apply('{1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1 chk("wb0_we", bus.ramWe, 0);
    tick();
    apply('{1, 0, 32'hFFFFFFFF, 0, 0, 1, 1, 9, 32'h99, 0, 0, 0});
    #1 chk("wb0_dbg_gnt", bus.dbgGnt, 1);
    chk("wb0_dbg_addr", bus.ramWAddr, 9);
    tick();
    apply('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    tick();
    chk("rd0", bus.rdData, 0);
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_gnt", i), bus.dbgGnt, vecs[i].e_gnt);
      chk($sformatf("vec%0d_we", i), bus.ramWe, vecs[i].e_we);
      if (vecs[i].e_we) chk($sformatf("vec%0d_wa", i), bus.ramWAddr, vecs[i].e_wa);
      tick();
      if (i == 3) chk("dbg_rd3", bus.dbgRdata, 32'hA5A5A5A5);
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (DEPTH - 1) tick();
    chk("restart_busy", bus.busy, 1);
    tick();
    apply('{1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tick();
    apply('{0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0});
    rst = 1'b1;
    tick();
    chk("rst_rdValid", bus.rdValid, 0);
    chk("rst_busy", bus.busy, 1);
    rst = 1'b0;
    idle();
    repeat (DEPTH) tick();
    apply('{0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0});
    tick();
    chk("rd5_cleared", bus.rdData, 0);
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.wbWe = 1'($urandom_range(0, 1));
      bus.wbAddr = AW'($urandom_range(0, 7));
      bus.wbData = $urandom;
      bus.rdEn = 1'($urandom_range(0, 1));
      bus.rdAddr = AW'($urandom_range(0, 7));
      if (!hold) begin
        bus.dbgReq = 1'($urandom_range(0, 1));
        bus.dbgWe = 1'($urandom_range(0, 1));
        bus.dbgAddr = AW'($urandom_range(0, 7));
        bus.dbgWdata = $urandom;
      end
      tick();
      hold = bus.dbgReq && !last_gnt;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
